// File: rtl/int_ctrl.sv
// int_ctrl: interrupt controller merging synchronised peripheral requests into one CP0 request.
//   clk     : system clock, rising edge
//   reset   : asynchronous active-low reset
//   ADDR    : bridge address, ADDR[3:2] selects MASK/MODE/PEND/CLAIM
//   IcWe    : write strobe (MASK, MODE, PEND W1C, EOI)
//   IcRe    : read strobe, triggers the claim side effect at offset 3
//   Din     : write data
//   Dout    : combinational read data
//   IRQ_in  : raw, possibly asynchronous, peripheral requests
//   IRQ     : registered request to CP0
module int_ctrl #(
   parameter int NSRC = 6
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [31:0]     ADDR,
   input  logic            IcWe,
   input  logic            IcRe,
   input  logic [31:0]     Din,
   output logic [31:0]     Dout,
   input  logic [NSRC-1:0] IRQ_in,
   output logic            IRQ
);
   logic [NSRC-1:0] mask_q, mask_d, mode_q, mode_d, pend_q, pend_d, isr_q, isr_d;
   logic [NSRC-1:0] s1_q, s2_q, s2_dly_q;
   logic            irq_q, irq_d;
   logic [NSRC-1:0] isr_low, below_top, elig, claim_oh, eoi_oh, clr;
   logic [4:0]      id;
   logic [1:0]      sel;
   logic            claim;
   logic            unused_bits;

   function automatic logic [31:0] ext(input logic [NSRC-1:0] v);
      ext = '0;
      ext[NSRC-1:0] = v;
   endfunction

   assign sel         = ADDR[3:2];
   assign unused_bits = ^{ADDR[31:4], ADDR[1:0]};

   // Only sources strictly above the highest-priority in-service source may interrupt.
   assign isr_low   = isr_q & (~isr_q + NSRC'(1));
   assign below_top = (isr_q == '0) ? '1 : isr_low - NSRC'(1);
   assign elig      = pend_q & mask_q & below_top;

   always_comb begin
      id = '0;
      for (int i = NSRC - 1; i >= 0; i--)
         if (elig[i]) id = 5'(i);
   end

   // A simultaneous write wins over the claim side effect.
   assign claim    = IcRe && !IcWe && sel == 2'd3 && |elig;
   assign claim_oh = claim ? NSRC'(1) << id : '0;
   // Ids at or beyond NSRC shift out to zero and are ignored.
   assign eoi_oh   = (IcWe && sel == 2'd3) ? NSRC'(1) << Din[4:0] : '0;
   assign clr      = ((IcWe && sel == 2'd2) ? Din[NSRC-1:0] : '0) | claim_oh;

   assign mask_d = (IcWe && sel == 2'd0) ? Din[NSRC-1:0] : mask_q;
   assign mode_d = (IcWe && sel == 2'd1) ? Din[NSRC-1:0] : mode_q;
   // Edge bits: a new rising edge beats a same-cycle clear.
   assign pend_d = (mode_q & ((pend_q & ~clr) | (s2_q & ~s2_dly_q))) | (~mode_q & s2_q);
   assign isr_d  = (isr_q | claim_oh) & ~eoi_oh;
   assign irq_d  = |elig;

   assign Dout = sel == 2'd0 ? ext(mask_q) :
                 sel == 2'd1 ? ext(mode_q) :
                 sel == 2'd2 ? ext(pend_q) :
                 |elig       ? {1'b1, 26'b0, id} : '0;
   assign IRQ  = irq_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mask_q   <= '0;
         mode_q   <= '0;
         pend_q   <= '0;
         isr_q    <= '0;
         s1_q     <= '0;
         s2_q     <= '0;
         s2_dly_q <= '0;
         irq_q    <= 1'b0;
      end else begin
         mask_q   <= mask_d;
         mode_q   <= mode_d;
         pend_q   <= pend_d;
         isr_q    <= isr_d;
         s1_q     <= IRQ_in;
         s2_q     <= s1_q;
         s2_dly_q <= s2_q;
         irq_q    <= irq_d;
      end
   end
endmodule

// File: tb/tb_int_ctrl.sv
// tb_int_ctrl: scoreboard bench for int_ctrl latency, claim/EOI, priority, W1C and reset.
module tb_int_ctrl;
   localparam int NSRC = 6;
   logic            clk = 1'b0, reset = 1'b0, IcWe = 1'b0, IcRe = 1'b0, IRQ;
   logic [31:0]     ADDR = '0, Din = '0, Dout;
   logic [NSRC-1:0] IRQ_in = '0;
   int              checks = 0, errors = 0;
   logic [31:0]     exp_q[$];
   string           tag_q[$];

   int_ctrl #(.NSRC(NSRC)) dut (
      .clk(clk), .reset(reset), .ADDR(ADDR), .IcWe(IcWe), .IcRe(IcRe),
      .Din(Din), .Dout(Dout), .IRQ_in(IRQ_in), .IRQ(IRQ)
   );

   always #10 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic sb_push(input string tag, input logic [31:0] v);
      tag_q.push_back(tag);
      exp_q.push_back(v);
   endtask

   task automatic sb_pop(input logic [31:0] obs);
      string t;
      logic [31:0] e;
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      check(t, obs, e);
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      ADDR = {28'b0, a, 2'b0};
      Din  = d;
      IcWe = 1'b1;
      tick();
      IcWe = 1'b0;
   endtask

   task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] e);
      sb_push(tag, e);
      ADDR = {28'b0, a, 2'b0};
      #1;
      sb_pop(Dout);
   endtask

   task automatic claim_chk(input string tag, input logic [31:0] e);
      sb_push(tag, e);
      ADDR = 32'hC;
      IcRe = 1'b1;
      #1;
      sb_pop(Dout);
      tick();
      IcRe = 1'b0;
   endtask

   task automatic irq_chk(input string tag, input logic e);
      sb_push(tag, {31'b0, e});
      sb_pop({31'b0, IRQ});
   endtask

   initial begin
      ticks(2);
      irq_chk("rst_irq", 1'b0);
      rd_chk("rst_mask", 2'd0, 32'h0);
      rd_chk("rst_mode", 2'd1, 32'h0);
      rd_chk("rst_pend", 2'd2, 32'h0);
      rd_chk("rst_claim", 2'd3, 32'h0);
      reset = 1'b1;
      tick();
      wr(2'd0, 32'hFFFF_FFFF);
      rd_chk("mask_upper", 2'd0, 32'h3F);
      wr(2'd1, 32'h0);
      IRQ_in[2] = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         tick();
         irq_chk($sformatf("latency_edge%0d", i), i == 4);
      end
      rd_chk("lvl_pend", 2'd2, 32'h04);
      claim_chk("claim2", 32'h8000_0002);
      irq_chk("irq_claim_c", 1'b1);
      tick();
      irq_chk("irq_claim_c1", 1'b0);
      IRQ_in[2] = 1'b0;
      ticks(3);
      rd_chk("lvl_drop", 2'd2, 32'h0);
      wr(2'd3, 32'd2);
      tick();
      irq_chk("eoi2_irq", 1'b0);
      claim_chk("claim_empty", 32'h0);
      rd_chk("claim_empty_pend", 2'd2, 32'h0);
      // edge mode on source 1
      wr(2'd1, 32'h02);
      IRQ_in[1] = 1'b1; ticks(3); IRQ_in[1] = 1'b0; ticks(3);
      rd_chk("edge_pend", 2'd2, 32'h02);
      irq_chk("edge_irq", 1'b1);
      claim_chk("claim1", 32'h8000_0001);
      rd_chk("edge_claim_clr", 2'd2, 32'h0);
      tick();
      IRQ_in[1] = 1'b1; ticks(3); IRQ_in[1] = 1'b0; ticks(3);
      rd_chk("edge_pend2", 2'd2, 32'h02);
      irq_chk("insvc_block", 1'b0);
      wr(2'd3, 32'd1);
      irq_chk("eoi1_c", 1'b0);
      tick();
      irq_chk("eoi1_c1", 1'b1);
      claim_chk("claim1b", 32'h8000_0001);
      wr(2'd3, 32'd1);
      tick();
      irq_chk("idle_irq", 1'b0);
      // priority and nesting
      wr(2'd1, 32'h13);
      IRQ_in = 6'h11; ticks(3); IRQ_in = '0; ticks(3);
      rd_chk("prio_pend", 2'd2, 32'h11);
      claim_chk("claim0", 32'h8000_0000);
      claim_chk("nest_block", 32'h0);
      rd_chk("nest_pend", 2'd2, 32'h10);
      irq_chk("nest_irq", 1'b0);
      wr(2'd3, 32'd0);
      claim_chk("claim4", 32'h8000_0004);
      wr(2'd3, 32'd4);
      rd_chk("prio_done", 2'd2, 32'h0);
      // W1C colliding with a new edge
      IRQ_in[1] = 1'b1; ticks(2);
      wr(2'd2, 32'h02);
      rd_chk("w1c_set_wins", 2'd2, 32'h02);
      IRQ_in[1] = 1'b0; ticks(3);
      rd_chk("w1c_hold", 2'd2, 32'h02);
      irq_chk("w1c_irq", 1'b1);
      wr(2'd2, 32'h02);
      rd_chk("w1c_clear", 2'd2, 32'h0);
      IRQ_in[1] = 1'b1; ticks(3); IRQ_in[1] = 1'b0; ticks(3);
      wr(2'd0, 32'h0);
      tick();
      irq_chk("masked_irq", 1'b0);
      claim_chk("masked_claim", 32'h0);
      rd_chk("masked_pend", 2'd2, 32'h02);
      wr(2'd0, 32'h3F);
      irq_chk("unmask_c", 1'b0);
      tick();
      irq_chk("unmask_c1", 1'b1);
      // boundaries
      claim_chk("claim1c", 32'h8000_0001);
      wr(2'd3, 32'd31);
      IRQ_in[3] = 1'b1;
      ticks(4);
      claim_chk("eoi31_ignored", 32'h0);
      irq_chk("eoi31_irq", 1'b0);
      wr(2'd3, 32'd1);
      tick();
      irq_chk("eoi1_lvl3", 1'b1);
      sb_push("we_re_read", 32'h8000_0003);
      ADDR = 32'hC; Din = 32'd31; IcWe = 1'b1; IcRe = 1'b1;
      #1;
      sb_pop(Dout);
      tick();
      IcWe = 1'b0; IcRe = 1'b0;
      tick();
      irq_chk("we_re_noclaim", 1'b1);
      claim_chk("claim3", 32'h8000_0003);
      rd_chk("lvl_stays", 2'd2, 32'h08);
      // asynchronous reset between edges
      tick();
      #1 reset = 1'b0;
      #1;
      irq_chk("arst_irq", 1'b0);
      rd_chk("arst_mask", 2'd0, 32'h0);
      rd_chk("arst_mode", 2'd1, 32'h0);
      rd_chk("arst_pend", 2'd2, 32'h0);
      rd_chk("arst_claim", 2'd3, 32'h0);
      reset = 1'b1;
      tick();
      check("sb_drain", exp_q.size(), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/int_ctrl.md
# int_ctrl

Interrupt controller between the memory-mapped peripherals (Timer, UART, further devices) and CP0. Each peripheral `IRQ` line is synchronised and latched as pending, per-source in level or edge mode. Pending sources are gated by a mask and by an in-service priority register, then merged into one registered request. The CPU reads the highest-priority source over the system bridge (claim) and retires it with an end-of-interrupt write (EOI).

## Interface
- `NSRC`, default 6: number of interrupt sources, 1..32; source 0 has the highest priority.
- `clk`  in  1  system clock, all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `ADDR`  in  32  bridge address; only `ADDR[3:2]` is decoded.
- `IcWe`  in  1  write strobe.
- `IcRe`  in  1  read strobe; only used for the claim side effect.
- `Din`  in  32  write data.
- `Dout`  out  32  read data, combinational from `ADDR[3:2]`.
- `IRQ_in`  in  NSRC  raw peripheral requests; may be asynchronous.
- `IRQ`  out  1  registered request to CP0.

## Operation
- Register map, indexed by `ADDR[3:2]`:
  - 0 MASK: read/write, bits `[NSRC-1:0]`; 1 enables the source.
  - 1 MODE: read/write; 1 = edge, 0 = level.
  - 2 PEND: read; a write clears the edge-mode bits written as 1 (write-1-to-clear).
  - 3 CLAIM/EOI: see below.
- In all registers, bits above `NSRC-1` read 0 and ignore writes.
- Synchroniser: two flops per source (`s1`, `s2`). `s2_d` is `s2` delayed one cycle.
- PEND update, evaluated per bit every cycle:
  - Level mode: `PEND <= s2`.
  - Edge mode: `PEND <= (PEND & ~clr) | (s2 & ~s2_d)`.
  - `clr` = W1C data, or the claimed bit. A set and a clear in the same cycle leave the bit set.
- In-service register ISR (NSRC bits, not readable). Let `top` = index of the lowest set ISR bit, or NSRC if ISR = 0.
- Eligible sources: `E = PEND & MASK & {bits with index < top}`.
- Output: `IRQ <= |E`, registered.
- CLAIM read at offset 3: `Dout = {E!=0, 26'b0, id[4:0]}`, where `id` = lowest set index in E. If E = 0, `Dout` = 0.
- Claim side effect: when `IcRe`=1, `ADDR[3:2]`=3 and E≠0:
  - `ISR[id] <= 1`.
  - `PEND[id]` is cleared if edge mode. A level source stays pending until the device deasserts.
- EOI: a write to offset 3 sets `ISR[Din[4:0]] <= 0`. Out-of-range ids and ids already clear are ignored.
- Nested service: a claim while ISR≠0 can only return an id below `top`. A lower-priority source waits for EOI.
- `IcWe` and `IcRe` both high in one cycle: the write executes and the claim side effect is suppressed.
- MODE change from level to edge: the PEND bit holds its last value, then follows edge rules. A change from edge to level overwrites it with `s2` on the next edge.
- MASK only gates E and IRQ, never PEND. Unmasking an already-pending source raises IRQ on the following cycle.

## Timing
- Reset (asynchronous, `reset`=0): MASK, MODE, PEND, ISR, `s1`, `s2`, `s2_d` and `IRQ` all go to 0. `Dout` then reads 0 at every offset.
- Deasserting reset needs no extra cycles; normal operation starts at the next rising edge.
- Source rise captured at edge k:
  - `s2` is high after k+1.
  - PEND is set after k+2.
  - `IRQ` is high after k+3. Same latency in both modes.
- Claim at edge c: ISR and PEND update at c. `IRQ` reflects the new E after c+1.
- EOI at edge c: the next-priority source is eligible immediately. `IRQ` updates after c+1.
- Edge mode: pulses shorter than one clock may be missed. Pulses at least 2 clocks wide, with at least 2 low clocks between them, are guaranteed to register.
- An edge that arrives while the same bit is still pending merges into that bit; there is no counting.
- Reset mid-service clears ISR and all PEND; any in-progress handler state is lost.

## Test plan
- Reset, then MASK=0x3F, MODE=0. Raise `IRQ_in[2]` → `IRQ`=1 exactly 4 edges later; CLAIM reads 0x80000002; drop the source → `IRQ`=0 three edges later, after EOI 2.
- Edge mode on source 1 (MODE=0x02). Give a 3-cycle pulse → PEND=0x02, claim returns 0x80000001, PEND=0. A second pulse before EOI → PEND=0x02, but IRQ stays 0 because source 1 is in service. EOI 1 → IRQ=1.
- Priority and nesting: pend sources 4 and 0 together → claim returns id 0. While 0 is in service, source 4 is blocked; after EOI 0, claim returns id 4.
- W1C and set in the same cycle on an edge source → PEND bit remains 1. A plain W1C of 0x02 with no new edge → bit cleared. MASK=0 with PEND set → IRQ=0 and CLAIM reads 0.
- Boundaries:
  - EOI with id 31 (out of range) → ISR unchanged.
  - `IcWe` and `IcRe` together at offset 3 → no claim side effect.
  - Claim with E=0 → `Dout`=0 and no state change.
- Assert `reset` asynchronously mid-service, between clock edges → all registers and `IRQ` read 0 before the next edge.
